// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 signed/unsigned multiply and restoring divide
// Operands are reduced to magnitudes at Start; the sign is reapplied once in FIXUP.
module mul_div_unit #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             is_div;
  logic             quo_neg;
  logic             rem_neg;
  logic             div_zero;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_orig;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_abs = (Op[0] && A[WIDTH-1]) ? -A : A;
  assign b_abs = (Op[0] && B[WIDTH-1]) ? -B : B;

  assign add_sum = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
  assign shifted = {acc, q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd};

  assign prod_fix = quo_neg ? -{acc, q} : {acc, q};
  assign quo_fix  = quo_neg ? -q : q;
  assign rem_fix  = rem_neg ? -acc : acc;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      DivByZero <= 1'b0;
      is_div    <= 1'b0;
      quo_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      div_zero  <= 1'b0;
      acc       <= '0;
      q         <= '0;
      opnd      <= '0;
      a_orig    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            is_div    <= Op[1];
            opnd      <= b_abs;
            q         <= a_abs;
            acc       <= '0;
            a_orig    <= A;
            quo_neg   <= Op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
            rem_neg   <= Op[0] & A[WIDTH-1];
            div_zero  <= Op[1] & (B == '0);
            count     <= CNT_W'(WIDTH);
            Busy      <= 1'b1;
            DivByZero <= 1'b0;
            state     <= ITER;
          end
        end
        ITER: begin
          if (is_div) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            if (!diff[WIDTH]) begin
              acc <= diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= shifted[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= add_sum[WIDTH:1];
            q   <= {add_sum[0], q[WIDTH-1:1]};
          end
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= FIXUP;
        end
        FIXUP: begin
          if (!is_div) begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            Hi <= a_orig;
            Lo <= '1;
          end else begin
            Hi <= rem_fix;
            Lo <= quo_fix;
          end
          DivByZero <= div_zero;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed bench for mul_div_unit with an arithmetic reference model
module tb_mul_div_unit;

  localparam int W  = 24;
  localparam int WS = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  A, B;
  logic          Busy, Done, DivByZero;
  logic [W-1:0]  Hi, Lo;

  logic          start_s;
  logic [1:0]    op_s;
  logic [WS-1:0] a_s, b_s;
  logic          busy_s, done_s, dbz_s;
  logic [WS-1:0] hi_s, lo_s;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
  );

  mul_div_unit #(.WIDTH(WS)) dut_s (
    .Clock(Clock), .Reset(Reset), .Start(start_s), .Op(op_s), .A(a_s), .B(b_s),
    .Busy(busy_s), .Done(done_s), .Hi(hi_s), .Lo(lo_s), .DivByZero(dbz_s)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int busy_cnt = 0;

  always @(posedge Clock) edge_n++;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           start;
  } exp_t;

  exp_t expq[$];
  exp_t cur;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended operands.
  function automatic void model(input logic [1:0] op, input longint a, input longint b,
                                input int w, output longint hi, output longint lo,
                                output logic dbz);
    longint mask, sa, sb, p;
    mask = (longint'(1) << w) - 1;
    sa = a;
    sb = b;
    if (op[0] && a[w-1]) sa = a - (longint'(1) << w);
    if (op[0] && b[w-1]) sb = b - (longint'(1) << w);
    dbz = 1'b0;
    if (!op[1]) begin
      p  = sa * sb;
      hi = (p >>> w) & mask;
      lo = p & mask;
    end else if (b == 0) begin
      hi  = a;
      lo  = mask;
      dbz = 1'b1;
    end else begin
      hi = (sa % sb) & mask;
      lo = (sa / sb) & mask;
    end
  endfunction

  task automatic pin(input string name, input logic [1:0] op, input longint a, input longint b,
                     input int w, input longint ehi, input longint elo, input logic edbz);
    longint h, l;
    logic d;
    model(op, a, b, w, h, l, d);
    chk({name, "_hi"}, h, ehi);
    chk({name, "_lo"}, l, elo);
    chk({name, "_dbz"}, longint'(d), longint'(edbz));
  endtask

  // Single compare process for the 24-bit unit: every Done is matched against the queue.
  always @(negedge Clock) begin
    if (Reset) begin
      busy_cnt = 0;
    end else begin
      if (Busy) busy_cnt++;
      if (Done) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur = expq.pop_front();
          chk("hi", longint'(Hi), longint'(cur.hi));
          chk("lo", longint'(Lo), longint'(cur.lo));
          chk("dbz", longint'(DivByZero), longint'(cur.dbz));
          chk("latency", longint'(edge_n + 1 - cur.start), longint'(W + 2));
          chk("busy_cycles", longint'(busy_cnt), longint'(W + 1));
          chk("busy_at_done", longint'(Busy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  // Caller is at a negedge with the unit idle (or in its Done cycle).
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint h, l;
    logic d;
    exp_t e;
    model(op, longint'(a), longint'(b), W, h, l, d);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(posedge Clock);
    #1;
    e.hi = h[W-1:0];
    e.lo = l[W-1:0];
    e.dbz = d;
    e.start = edge_n;
    expq.push_back(e);
    Start = 1'b0;
    Op = 2'($urandom);
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (expq.size() != 0) begin
      chk("timeout", 1, 0);
      expq.delete();
    end
    @(negedge Clock);
  endtask

  task automatic run_small(input logic [1:0] op, input logic [WS-1:0] a, input logic [WS-1:0] b);
    longint h, l;
    logic d;
    int s, n;
    model(op, longint'(a), longint'(b), WS, h, l, d);
    @(negedge Clock);
    start_s = 1'b1;
    op_s = op;
    a_s = a;
    b_s = b;
    @(posedge Clock);
    #1;
    s = edge_n;
    start_s = 1'b0;
    a_s = '0;
    b_s = '0;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!done_s && n < 50);
    if (!done_s) begin
      chk("small_timeout", 1, 0);
    end else begin
      chk("small_hi", longint'(hi_s), h);
      chk("small_lo", longint'(lo_s), l);
      chk("small_dbz", longint'(dbz_s), longint'(d));
      chk("small_latency", longint'(edge_n + 1 - s), longint'(WS + 2));
      chk("small_busy", longint'(busy_s), 0);
    end
  endtask

  initial begin
    int seen, n;
    Reset = 1'b1;
    Start = 1'b0;
    Op = '0;
    A = '0;
    B = '0;
    start_s = 1'b0;
    op_s = '0;
    a_s = '0;
    b_s = '0;
    repeat (2) @(negedge Clock);
    chk("rst_busy", longint'(Busy), 0);
    chk("rst_done", longint'(Done), 0);
    chk("rst_hi", longint'(Hi), 0);
    chk("rst_lo", longint'(Lo), 0);
    chk("rst_dbz", longint'(DivByZero), 0);
    Reset = 1'b0;
    @(negedge Clock);

    pin("m_mulu_max", 2'b00, 64'hFFFFFF, 64'hFFFFFF, W, 64'hFFFFFE, 64'h000001, 1'b0);
    pin("m_mul_neg", 2'b01, 64'hFFFFFD, 64'h000005, W, 64'hFFFFFF, 64'hFFFFF1, 1'b0);
    pin("m_mul_min", 2'b01, 64'h800000, 64'h800000, W, 64'h400000, 64'h000000, 1'b0);
    pin("m_div_neg", 2'b11, 64'hFFFFF9, 64'h000002, W, 64'hFFFFFF, 64'hFFFFFD, 1'b0);
    pin("m_divu", 2'b10, 64'h000064, 64'h000007, W, 64'h000002, 64'h00000E, 1'b0);
    pin("m_div0", 2'b10, 64'h000064, 64'h000000, W, 64'h000064, 64'hFFFFFF, 1'b1);
    pin("m_div_ovf", 2'b11, 64'h800000, 64'hFFFFFF, W, 64'h000000, 64'h800000, 1'b0);
    pin("m_small", 2'b00, 64'hFF, 64'hFF, WS, 64'hFE, 64'h01, 1'b0);

    issue(2'b00, 24'hFFFFFF, 24'hFFFFFF); wait_idle();
    issue(2'b01, 24'hFFFFFD, 24'h000005); wait_idle();
    issue(2'b01, 24'h800000, 24'h800000); wait_idle();
    issue(2'b11, 24'hFFFFF9, 24'h000002); wait_idle();
    issue(2'b10, 24'h000064, 24'h000007); wait_idle();
    issue(2'b11, 24'h000007, 24'hFFFFFE); wait_idle();
    issue(2'b01, 24'hFFFFFF, 24'hFFFFFF); wait_idle();
    issue(2'b10, 24'hFFFFFF, 24'h000001); wait_idle();
    issue(2'b11, 24'hFFFFF9, 24'h000000); wait_idle();
    issue(2'b10, 24'h000064, 24'h000000); wait_idle();
    repeat (3) @(negedge Clock);
    chk("dbz_hold", longint'(DivByZero), 1);
    chk("hi_hold", longint'(Hi), 64'h64);
    issue(2'b11, 24'h800000, 24'hFFFFFF);
    chk("dbz_cleared", longint'(DivByZero), 0);
    chk("hi_kept_on_start", longint'(Hi), 64'h64);
    chk("lo_kept_on_start", longint'(Lo), 64'hFFFFFF);
    wait_idle();

    // Starts during Busy must be ignored.
    issue(2'b10, 24'h123456, 24'h000321);
    repeat (4) @(negedge Clock);
    Start = 1'b1; Op = 2'b00; A = 24'h000003; B = 24'h000004;
    @(negedge Clock);
    Start = 1'b0;
    repeat (6) @(negedge Clock);
    Start = 1'b1; Op = 2'b11; A = 24'h000009; B = 24'h000002;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();

    // Back-to-back: second Start driven in the Done cycle.
    issue(2'b00, 24'hABCDEF, 24'h000123);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!Done && n < 100);
    if (!Done) begin
      chk("b2b_timeout", 1, 0);
      expq.delete();
    end else begin
      issue(2'b01, 24'h800001, 24'h7FFFFF);
    end
    wait_idle();

    // Asynchronous reset in the middle of a multiply.
    issue(2'b00, 24'hFFFFFF, 24'hFFFFFF);
    repeat (9) @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_busy", longint'(Busy), 0);
    chk("arst_done", longint'(Done), 0);
    chk("arst_hi", longint'(Hi), 0);
    chk("arst_lo", longint'(Lo), 0);
    chk("arst_dbz", longint'(DivByZero), 0);
    expq.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge Clock);
      if (Done) seen = 1;
    end
    chk("no_done_after_reset", longint'(seen), 0);
    issue(2'b01, 24'hFFFFFD, 24'h000005); wait_idle();

    run_small(2'b00, 8'hFF, 8'hFF);
    run_small(2'b11, 8'h81, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit for the datapath. It supersedes the combinational multiplier plus 48-bit product register pair. It accepts signed or unsigned multiply and divide requests through a Start/Busy/Done handshake. Each request runs radix-2 over WIDTH cycles and returns a double-width result in Hi/Lo registers. It sits beside the ALU: operands come from the register-file read port and the ALU-source mux, and Hi/Lo feed the write-back mux.

## Interface

- WIDTH, 24, operand and Hi/Lo width; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- A  in  WIDTH  multiplicand / dividend.
- B  in  WIDTH  multiplier / divisor.
- Busy  out  1  high while a request is in progress.
- Done  out  1  one-cycle pulse; Hi/Lo/DivByZero are valid from this cycle on.
- Hi  out  WIDTH  product upper half / remainder.
- Lo  out  WIDTH  product lower half / quotient.
- DivByZero  out  1  set with Done when a divide had B == 0; cleared at the next accepted Start.

## Operation

- States: IDLE, ITER, FIXUP.
- IDLE:
  - Start=1 latches Op and the absolute values of A and B (absolute only for signed ops).
  - Records result sign: A^B sign bits for the product or quotient; A sign bit for the remainder.
  - Loads counter = WIDTH, clears the accumulator, goes to ITER.
- ITER: one step per cycle; counter decrements; at counter==1 goes to FIXUP.
  - MUL: shift-add. Accumulator:multiplier shifts right one bit; the multiplicand is added to the upper half when the multiplier LSB is 1. The add is WIDTH+1 bits wide to keep the carry.
  - DIV: restoring. Shift remainder:quotient left; trial-subtract the divisor using WIDTH+1 bits; shift in quotient bit 1 if non-negative, else restore.
- FIXUP:
  - Applies the two's-complement sign correction to the 2·WIDTH product, or separately to the quotient and remainder.
  - Writes Hi/Lo, pulses Done, goes to IDLE.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: runs the full latency. Lo = all ones, Hi = A (original, unmodified), DivByZero = 1.
- Signed overflow (A = most-negative, B = −1): Lo = A, Hi = 0, DivByZero = 0.
- Start while Busy=1 is ignored; the in-flight request is unaffected.
- Hi/Lo hold their value until the next FIXUP. They are not cleared by a new Start.

## Timing

- Reset values: Busy=0, Done=0, Hi=0, Lo=0, DivByZero=0, state IDLE, counter 0.
- Start sampled high in IDLE at edge k:
  - Busy=1 after edge k.
  - ITER steps occur on edges k+1 … k+WIDTH.
  - FIXUP state follows edge k+WIDTH.
  - Edge k+WIDTH+1 registers Hi/Lo/DivByZero, Done=1 and Busy=0.
- Latency is fixed at WIDTH+2 edges from Start sample to Done sample, independent of Op and operand values (26 for WIDTH=24).
- Done is high for exactly one cycle.
- Back-to-back: Start may be high in the Done cycle. It is accepted at that edge, with no idle gap.
- Operands A/B/Op need only be valid at the Start edge; later changes are ignored.
- Reset asserted mid-operation: immediate return to the reset state. The partial result is discarded and no Done is issued. The first Start after Reset deasserts is accepted normally.

## Test plan

- WIDTH=24, MULU A=0xFFFFFF, B=0xFFFFFF → Hi=0xFFFFFE, Lo=0x000001; Done exactly 26 edges after Start; Busy high for 25 cycles.
- MUL A=0xFFFFFD (−3), B=0x000005 → Hi=0xFFFFFF, Lo=0xFFFFF1 (−15); MUL A=0x800000, B=0x800000 → Hi=0x400000, Lo=0x000000.
- DIV A=0xFFFFF9 (−7), B=0x000002 → Lo=0xFFFFFD (−3), Hi=0xFFFFFF (−1); DIVU A=0x000064, B=0x000007 → Lo=0x00000E, Hi=0x000002.
- DIVU A=0x000064, B=0 → Lo=0xFFFFFF, Hi=0x000064, DivByZero=1 with Done. Next accepted Start clears DivByZero. DIV A=0x800000, B=0xFFFFFF → Lo=0x800000, Hi=0, DivByZero=0.
- Start pulsed with new operands at cycles 5 and 12 during Busy → ignored; the original result is returned. Start held high in the Done cycle → second request completes exactly 26 edges later.
- Reset asserted at cycle 10 of a MULU, asynchronously between edges → all outputs 0 immediately; no Done. A fresh request after release completes correctly; a WIDTH=8 instance returns 0xFF·0xFF → Hi=0xFE, Lo=0x01 after 10 edges.
